// File: rtl/ortak_birim_hakem.sv
// Round-robin arbiter that shares one multi-cycle functional unit between two requesters.
// Sequences start -> wait for done -> hold result, with flush handling and a watchdog abort.
module ortak_birim_hakem #(
    parameter int unsigned VERI_BIT    = 32,
    parameter int unsigned ETIKET_BIT  = 4,
    parameter int unsigned KOD_BIT     = 3,
    parameter int unsigned ZAMAN_ASIMI = 64
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  istek0_gecerli_i,
    input  logic [KOD_BIT-1:0]    istek0_kod_i,
    input  logic [VERI_BIT-1:0]   istek0_islec1_i,
    input  logic [VERI_BIT-1:0]   istek0_islec2_i,
    input  logic [ETIKET_BIT-1:0] istek0_etiket_i,
    output logic                  istek0_kabul_o,
    input  logic                  istek1_gecerli_i,
    input  logic [KOD_BIT-1:0]    istek1_kod_i,
    input  logic [VERI_BIT-1:0]   istek1_islec1_i,
    input  logic [VERI_BIT-1:0]   istek1_islec2_i,
    input  logic [ETIKET_BIT-1:0] istek1_etiket_i,
    output logic                  istek1_kabul_o,
    output logic                  birim_baslat_o,
    output logic [KOD_BIT-1:0]    birim_kod_o,
    output logic [VERI_BIT-1:0]   birim_islec1_o,
    output logic [VERI_BIT-1:0]   birim_islec2_o,
    input  logic                  birim_gecerli_i,
    input  logic [VERI_BIT-1:0]   birim_sonuc_i,
    output logic                  yanit_gecerli_o,
    output logic                  yanit_hedef_o,
    output logic [ETIKET_BIT-1:0] yanit_etiket_o,
    output logic [VERI_BIT-1:0]   yanit_sonuc_o,
    input  logic                  yanit_hazir_i,
    input  logic                  bosalt_i,
    output logic                  mesgul_o,
    output logic                  zaman_asimi_o
);

    localparam int unsigned SAYAC_BIT = $clog2(ZAMAN_ASIMI) + 1;
    localparam logic [SAYAC_BIT-1:0] SAYAC_SON = SAYAC_BIT'(ZAMAN_ASIMI - 1);

    typedef enum logic [2:0] {
        BOSTA  = 3'd0,
        BASLAT = 3'd1,
        BEKLE  = 3'd2,
        YANIT  = 3'd3,
        IPTAL  = 3'd4
    } durum_t;

    durum_t                durum_q, durum_d;
    logic                  oncelik_q, oncelik_d;
    logic [SAYAC_BIT-1:0]  sayac_q, sayac_d;
    logic [KOD_BIT-1:0]    kod_q, kod_d;
    logic [VERI_BIT-1:0]   islec1_q, islec1_d;
    logic [VERI_BIT-1:0]   islec2_q, islec2_d;
    logic [ETIKET_BIT-1:0] etiket_q, etiket_d;
    logic                  sahip_q, sahip_d;
    logic [VERI_BIT-1:0]   sonuc_q, sonuc_d;
    logic                  secilen;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            durum_q   <= BOSTA;
            oncelik_q <= 1'b0;
            sayac_q   <= '0;
            kod_q     <= '0;
            islec1_q  <= '0;
            islec2_q  <= '0;
            etiket_q  <= '0;
            sahip_q   <= 1'b0;
            sonuc_q   <= '0;
        end else begin
            durum_q   <= durum_d;
            oncelik_q <= oncelik_d;
            sayac_q   <= sayac_d;
            kod_q     <= kod_d;
            islec1_q  <= islec1_d;
            islec2_q  <= islec2_d;
            etiket_q  <= etiket_d;
            sahip_q   <= sahip_d;
            sonuc_q   <= sonuc_d;
        end
    end

    always_comb begin
        durum_d         = durum_q;
        oncelik_d       = oncelik_q;
        sayac_d         = sayac_q;
        kod_d           = kod_q;
        islec1_d        = islec1_q;
        islec2_d        = islec2_q;
        etiket_d        = etiket_q;
        sahip_d         = sahip_q;
        sonuc_d         = sonuc_q;
        istek0_kabul_o  = 1'b0;
        istek1_kabul_o  = 1'b0;
        birim_baslat_o  = 1'b0;
        yanit_gecerli_o = 1'b0;
        zaman_asimi_o   = 1'b0;
        // 1 selects requester 1: the priority holder if valid, otherwise the other one
        secilen = oncelik_q ? istek1_gecerli_i : !istek0_gecerli_i;

        unique case (durum_q)
            BOSTA: begin
                // rstn_i gating keeps the combinational grant low while reset is held
                if (rstn_i && !bosalt_i && (istek0_gecerli_i || istek1_gecerli_i)) begin
                    istek0_kabul_o = !secilen;
                    istek1_kabul_o = secilen;
                    kod_d     = secilen ? istek1_kod_i    : istek0_kod_i;
                    islec1_d  = secilen ? istek1_islec1_i : istek0_islec1_i;
                    islec2_d  = secilen ? istek1_islec2_i : istek0_islec2_i;
                    etiket_d  = secilen ? istek1_etiket_i : istek0_etiket_i;
                    sahip_d   = secilen;
                    oncelik_d = !secilen;
                    durum_d   = BASLAT;
                end
            end
            BASLAT: begin
                birim_baslat_o = !bosalt_i;
                sayac_d        = '0;
                durum_d        = bosalt_i ? BOSTA : BEKLE;
            end
            BEKLE: begin
                sayac_d = sayac_q + SAYAC_BIT'(1);
                if (birim_gecerli_i) begin
                    if (bosalt_i) begin
                        durum_d = BOSTA;
                    end else begin
                        sonuc_d = birim_sonuc_i;
                        durum_d = YANIT;
                    end
                end else if (sayac_q == SAYAC_SON) begin
                    zaman_asimi_o = 1'b1;
                    durum_d       = BOSTA;
                end else if (bosalt_i) begin
                    durum_d = IPTAL;
                end
            end
            IPTAL: begin
                sayac_d = sayac_q + SAYAC_BIT'(1);
                if (birim_gecerli_i) begin
                    durum_d = BOSTA;
                end else if (sayac_q == SAYAC_SON) begin
                    zaman_asimi_o = 1'b1;
                    durum_d       = BOSTA;
                end
            end
            YANIT: begin
                yanit_gecerli_o = 1'b1;
                if (bosalt_i || yanit_hazir_i) begin
                    durum_d = BOSTA;
                end
            end
            default: durum_d = BOSTA;
        endcase
    end

    assign birim_kod_o    = kod_q;
    assign birim_islec1_o = islec1_q;
    assign birim_islec2_o = islec2_q;
    assign yanit_hedef_o  = sahip_q;
    assign yanit_etiket_o = etiket_q;
    assign yanit_sonuc_o  = sonuc_q;
    assign mesgul_o       = (durum_q != BOSTA);

endmodule
